// File: rtl/rega_timer_ctrl_pkg.sv
// rega_pkg: shared state encoding and BCD limits for the irrigation run controller
package rega_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_ok(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/rega_timer_ctrl_if.sv
// rega_timer_ctrl_if: operator/sensor requests in, valve drive and BCD display out
interface rega_timer_ctrl_if;

    logic       Start;
    logic       Stop;
    logic       Wet;
    logic [3:0] DurT;
    logic [3:0] DurU;
    logic       Valve;
    logic       Busy;
    logic       Done;
    logic       Err;
    logic [3:0] CntT;
    logic [3:0] CntU;

    modport master (
        output Start, Stop, Wet, DurT, DurU,
        input  Valve, Busy, Done, Err, CntT, CntU
    );

    modport slave (
        input  Start, Stop, Wet, DurT, DurU,
        output Valve, Busy, Done, Err, CntT, CntU
    );

endinterface

// File: rtl/rega_timer_ctrl_bcd_digit_down.sv
// bcd_digit_down: one BCD down-counting digit with load and borrow chaining
module bcd_digit_down
    import rega_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    input  logic       bin_i,
    output logic [3:0] dig_o,
    output logic       bout_o
);

    logic [3:0] dig_q, dig_d;
    logic       dec;

    // load wins over decrement; a decrement from 0 wraps to 9 and borrows
    always_comb begin
        dec    = en_i && bin_i;
        bout_o = dec && (dig_q == 4'd0);
        dig_d  = load_i ? load_val_i
               : dec    ? ((dig_q == 4'd0) ? BCD_MAX : dig_q - 4'd1)
               :          dig_q;
    end

    // digit register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) dig_q <= 4'd0;
        else      dig_q <= dig_d;
    end

    assign dig_o = dig_q;

endmodule

// File: rtl/rega_timer_ctrl.sv
// rega_timer_ctrl: loads a BCD duration, opens the valve and counts down on a prescaled tick
module rega_timer_ctrl
    import rega_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int PRE_W    = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    rega_timer_ctrl_if.slave   bus
);

    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             err_q, err_d;
    logic             tick, ld;
    logic [3:0]       ld_t, ld_u;
    logic [3:0]       cnt_t, cnt_u;
    logic             borrow_u, borrow_t;
    logic             dur_bad, last;

    // Stop beats Wet beats tick in every state; a load of 00 doubles as the clear
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        err_d   = 1'b0;
        tick    = 1'b0;
        ld      = 1'b0;
        ld_t    = 4'd0;
        ld_u    = 4'd0;
        dur_bad = !bcd_ok(bus.DurT) || !bcd_ok(bus.DurU) || ({bus.DurT, bus.DurU} == 8'h00);
        last    = (cnt_t == 4'd0) && (cnt_u == 4'd1);
        case (state_q)
            ST_IDLE: begin
                if (bus.Stop) ld = 1'b1;
                else if (bus.Start && !bus.Wet) begin
                    if (dur_bad) err_d = 1'b1;
                    else begin
                        ld      = 1'b1;
                        ld_t    = bus.DurT;
                        ld_u    = bus.DurU;
                        pre_d   = '0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.Stop) begin
                    ld      = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.Wet) state_d = ST_HOLD;
                else begin
                    tick  = (pre_q == PRE_TOP);
                    pre_d = tick ? '0 : pre_q + PRE_W'(1);
                    if (tick && (last || borrow_t)) state_d = ST_DONE;
                end
            end
            ST_HOLD: begin
                if (bus.Stop) begin
                    ld      = 1'b1;
                    state_d = ST_IDLE;
                end else if (!bus.Wet) state_d = ST_RUN;
            end
            default: begin
                if (bus.Stop) ld = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, prescaler and rejected-start pulse registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            err_q   <= err_d;
        end
    end

    bcd_digit_down u_units (
        .Clk        (Clk),
        .Rst        (Rst),
        .load_i     (ld),
        .load_val_i (ld_u),
        .en_i       (tick),
        .bin_i      (1'b1),
        .dig_o      (cnt_u),
        .bout_o     (borrow_u)
    );

    bcd_digit_down u_tens (
        .Clk        (Clk),
        .Rst        (Rst),
        .load_i     (ld),
        .load_val_i (ld_t),
        .en_i       (tick),
        .bin_i      (borrow_u),
        .dig_o      (cnt_t),
        .bout_o     (borrow_t)
    );

    assign bus.Valve = (state_q == ST_RUN);
    assign bus.Busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign bus.Done  = (state_q == ST_DONE);
    assign bus.Err   = err_q;
    assign bus.CntT  = cnt_t;
    assign bus.CntU  = cnt_u;

endmodule
